// File: rtl/uart_rx_packet.sv
// Packet framer behind the UART receiver: hunts SOF, buffers a length-prefixed
// payload, verifies an 8-bit additive checksum and drains good frames over valid/ready.
`timescale 1ns/1ps

module uart_rx_packet #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 86800
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Pkt_Valid,
    output logic [7:0] o_Pkt_Data,
    output logic       o_Pkt_Last,
    input  logic       i_Pkt_Ready,
    output logic       o_Csum_Err,
    output logic       o_Len_Err,
    output logic       o_Timeout,
    output logic       o_Overrun
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t           state;
    logic [7:0]       pkt_buf [MAX_LEN];
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rd_nxt;
    logic [IDX_W-1:0] last_idx;
    logic [7:0]       sum;
    logic [CNT_W-1:0] tmo_cnt;
    logic             in_frame;
    logic             tmo_hit;
    logic             handshake;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

    assign in_frame  = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    // A byte arriving on the threshold cycle wins over the timeout.
    assign tmo_hit   = in_frame && !i_Rx_DV && (tmo_cnt == TMO_LAST);
    assign handshake = o_Pkt_Valid && i_Pkt_Ready;
    assign rd_nxt    = rd_idx + 1'b1;

    // Payload storage carries no reset; its contents only matter once a frame is accepted.
    always_ff @(posedge i_Clock) begin
        if (state == S_PAYLOAD && i_Rx_DV)
            pkt_buf[wr_idx] <= i_Rx_Byte;
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state       <= S_IDLE;
            wr_idx      <= '0;
            rd_idx      <= '0;
            last_idx    <= '0;
            sum         <= '0;
            tmo_cnt     <= '0;
            o_Pkt_Valid <= 1'b0;
            o_Pkt_Data  <= '0;
            o_Pkt_Last  <= 1'b0;
            o_Csum_Err  <= 1'b0;
            o_Len_Err   <= 1'b0;
            o_Timeout   <= 1'b0;
            o_Overrun   <= 1'b0;
        end else begin
            o_Csum_Err <= 1'b0;
            o_Len_Err  <= 1'b0;
            o_Timeout  <= 1'b0;
            o_Overrun  <= 1'b0;
            tmo_cnt    <= (in_frame && !i_Rx_DV) ? tmo_cnt + 1'b1 : '0;

            if (tmo_hit) begin
                o_Timeout <= 1'b1;
                tmo_cnt   <= '0;
                state     <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (i_Rx_DV && i_Rx_Byte == SOF_BYTE)
                            state <= S_LEN;
                    end

                    S_LEN: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == 8'd0 || i_Rx_Byte > MAX_LEN_B) begin
                                o_Len_Err <= 1'b1;
                                state     <= S_IDLE;
                            end else begin
                                last_idx <= IDX_W'(i_Rx_Byte - 8'd1);
                                sum      <= i_Rx_Byte;
                                wr_idx   <= '0;
                                state    <= S_PAYLOAD;
                            end
                        end
                    end

                    S_PAYLOAD: begin
                        if (i_Rx_DV) begin
                            sum    <= csum_add(sum, i_Rx_Byte);
                            wr_idx <= wr_idx + 1'b1;
                            if (wr_idx == last_idx)
                                state <= S_CSUM;
                        end
                    end

                    S_CSUM: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == sum) begin
                                rd_idx      <= '0;
                                o_Pkt_Valid <= 1'b1;
                                o_Pkt_Data  <= pkt_buf[0];
                                o_Pkt_Last  <= (last_idx == '0);
                                state       <= S_DRAIN;
                            end else begin
                                o_Csum_Err <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end
                    end

                    S_DRAIN: begin
                        // The buffer is busy; incoming bytes, even SOF, are dropped.
                        if (i_Rx_DV)
                            o_Overrun <= 1'b1;
                        if (handshake) begin
                            if (rd_idx == last_idx) begin
                                o_Pkt_Valid <= 1'b0;
                                o_Pkt_Data  <= '0;
                                o_Pkt_Last  <= 1'b0;
                                state       <= S_IDLE;
                            end else begin
                                rd_idx     <= rd_nxt;
                                o_Pkt_Data <= pkt_buf[rd_nxt];
                                o_Pkt_Last <= (rd_nxt == last_idx);
                            end
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_packet.sv
// Randomized bench for uart_rx_packet: a frame-level parser model predicts the
// drained payload and error-pulse counts; directed cases cover timing corners.
`timescale 1ns/1ps

module tb_uart_rx_packet;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 50;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_ready;
    logic       csum_err, len_err, tmo_err, ovr_err;

    uart_rx_packet #(.SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
        .i_Clock     (clk),
        .i_Rst_n     (rst_n),
        .i_Rx_DV     (rx_dv),
        .i_Rx_Byte   (rx_byte),
        .o_Pkt_Valid (pkt_valid),
        .o_Pkt_Data  (pkt_data),
        .o_Pkt_Last  (pkt_last),
        .i_Pkt_Ready (pkt_ready),
        .o_Csum_Err  (csum_err),
        .o_Len_Err   (len_err),
        .o_Timeout   (tmo_err),
        .o_Overrun   (ovr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Ready driver: random or forced, applied 2 time units after each edge.
    bit   rand_ready  = 1'b0;
    logic ready_force = 1'b1;
    initial begin
        pkt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            pkt_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Observed stream
    int         cyc = 0;
    logic [7:0] got_d[$];
    logic       got_l[$];
    int         got_c[$];
    int         n_csum = 0, n_len = 0, n_tmo = 0, n_ovr = 0, n_multi = 0, n_junk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (pkt_valid && pkt_ready) begin
                got_d.push_back(pkt_data);
                got_l.push_back(pkt_last);
                got_c.push_back(cyc);
            end
            n_csum <= n_csum + int'(csum_err);
            n_len  <= n_len + int'(len_err);
            n_tmo  <= n_tmo + int'(tmo_err);
            n_ovr  <= n_ovr + int'(ovr_err);
            if (int'(csum_err) + int'(len_err) + int'(tmo_err) + int'(ovr_err) > 1)
                n_multi <= n_multi + 1;
            if (!pkt_valid && (pkt_data != 8'h00 || pkt_last))
                n_junk <= n_junk + 1;
        end
    end

    // Reference model: parses a byte stream frame by frame.
    logic [7:0] seq[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    int         e_csum = 0, e_len = 0, e_tmo = 0, e_ovr = 0;

    task automatic model_seq();
        int i = 0;
        while (i < seq.size()) begin
            int         len;
            logic [7:0] s;
            if (seq[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= seq.size()) break;
            len = int'(seq[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                e_len++;
                i += 2;
                continue;
            end
            if (i + 2 + len >= seq.size()) break;
            s = 8'(len);
            for (int k = 0; k < len; k++) s = s + seq[i+2+k];
            if (seq[i+2+len] == s) begin
                for (int k = 0; k < len; k++) begin
                    exp_d.push_back(seq[i+2+k]);
                    exp_l.push_back(k == len - 1);
                end
            end else begin
                e_csum++;
            end
            i += 3 + len;
        end
        seq.delete();
    endtask

    task automatic add_frame(input int len, input bit bad);
        logic [7:0] s;
        logic [7:0] b;
        s = 8'(len);
        seq.push_back(8'hA5);
        seq.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
            b = 8'($urandom);
            s = s + b;
            seq.push_back(b);
        end
        seq.push_back(bad ? s + 8'(1 + $urandom_range(0, 254)) : s);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
        rx_byte = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_q(input int gap_max);
        for (int i = 0; i < seq.size(); i++) begin
            send_byte(seq[i]);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
        model_seq();
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (pkt_valid && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_drain_done"}, pkt_valid, 1'b0);
        idle(2);
    endtask

    task automatic cmp_payload(input string tag);
        chk({tag, "_count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            chk({tag, "_data"}, got_d[i], exp_d[i]);
            chk({tag, "_last"}, got_l[i], exp_l[i]);
        end
        got_d.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_l.delete();
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_csum_err"}, n_csum, e_csum);
        chk({tag, "_len_err"},  n_len,  e_len);
        chk({tag, "_timeout"},  n_tmo,  e_tmo);
        chk({tag, "_overrun"},  n_ovr,  e_ovr);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        idle(3);
        chk("rst_valid", pkt_valid, 1'b0);
        chk("rst_data",  pkt_data,  8'h00);
        chk("rst_last",  pkt_last,  1'b0);
        chk("rst_errs",  {csum_err, len_err, tmo_err, ovr_err}, 4'b0000);
        rst_n = 1'b1;
        idle(2);

        // Good frame, back-to-back bytes, ready held high
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
        chk("t1_lat_valid", pkt_valid, 1'b1);
        chk("t1_lat_data",  pkt_data,  8'h11);
        model_seq();
        wait_drain("t1");
        if (got_c.size() == 3) chk("t1_consecutive", got_c[2] - got_c[0], 2);
        else chk("t1_beats", got_c.size(), 3);
        cmp_payload("t1");
        chk_errs("t1");

        // Bad checksum then good frame
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
        send_q(0);
        idle(3);
        chk("t2_no_valid", got_d.size(), 0);
        add_frame(4, 1'b0);
        send_q(2);
        wait_drain("t2");
        cmp_payload("t2");
        chk_errs("t2");

        // Garbage and length errors, then a good frame
        seq = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'hA5, 8'h11};
        send_q(1);
        add_frame(2, 1'b0);
        send_q(0);
        wait_drain("t3");
        cmp_payload("t3");
        chk_errs("t3");

        // Timeout latency counted in edges from the edge accepting the last byte
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (tmo_err) break;
        end
        chk("t4_tmo_latency", n, TMO);
        e_tmo++;
        idle(1);
        chk("t4_tmo_one_cycle", tmo_err, 1'b0);
        // Byte on the threshold cycle keeps the frame alive
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
        idle(TMO - 1);
        send_byte(8'h22);
        send_byte(8'h35);
        seq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h35};
        model_seq();
        wait_drain("t4");
        cmp_payload("t4");
        chk_errs("t4");

        // Back-pressure on byte 2 with an overrun SOF during the stall
        ready_force = 1'b0;
        seq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
        model_seq();
        chk("t5_first", {pkt_valid, pkt_data, pkt_last}, {1'b1, 8'h11, 1'b0});
        ready_force = 1'b1;
        idle(1);
        ready_force = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                send_byte(8'hA5);
                e_ovr++;
                chk("t5_ovr_pulse", ovr_err, 1'b1);
            end else begin
                idle(1);
            end
            chk("t5_hold", {pkt_valid, pkt_data, pkt_last}, {1'b1, 8'h22, 1'b0});
        end
        ready_force = 1'b1;
        wait_drain("t5");
        cmp_payload("t5");
        chk_errs("t5");

        // Asynchronous reset mid-drain
        ready_force = 1'b0;
        seq = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h05};
        for (int i = 0; i < seq.size(); i++) send_byte(seq[i]);
        seq.delete();
        chk("t6_pre_rst_valid", pkt_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", pkt_valid, 1'b0);
        chk("t6_async_data",  pkt_data,  8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_force = 1'b1;
        idle(2);
        add_frame(5, 1'b0);
        send_q(1);
        wait_drain("t6");
        cmp_payload("t6");

        // Maximum length with a guaranteed wrapping sum
        begin
            logic [7:0] s;
            logic [7:0] b;
            s = 8'(MAX_LEN);
            seq = '{8'hA5, 8'(MAX_LEN)};
            for (int k = 0; k < MAX_LEN; k++) begin
                b = 8'hF0 | 8'($urandom_range(0, 15));
                s = s + b;
                seq.push_back(b);
            end
            seq.push_back(s);
        end
        send_q(0);
        wait_drain("t7");
        cmp_payload("t7");
        chk_errs("t7");

        // Random traffic with random back-pressure
        rand_ready = 1'b1;
        repeat (40) begin
            case ($urandom_range(0, 3))
                0: add_frame($urandom_range(1, MAX_LEN), 1'b0);
                1: add_frame($urandom_range(1, MAX_LEN), 1'b1);
                2: begin
                    seq.push_back(8'hA5);
                    seq.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
                end
                default: begin
                    repeat ($urandom_range(1, 4)) begin
                        logic [7:0] g;
                        g = 8'($urandom);
                        if (g == 8'hA5) g = 8'h5A;
                        seq.push_back(g);
                    end
                end
            endcase
            send_q(5);
            wait_drain("rnd");
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        idle(3);
        cmp_payload("rnd");
        chk_errs("rnd");
        chk("pulse_exclusive", n_multi, 0);
        chk("idle_outputs_zero", n_junk, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
